car_lane_driver: RTL and testbench

CAR_LANE_DRIVER -- requirements
Module: car_lane_driver

---
 rtl/car_lane_driver_pkg.sv | 8 +
 rtl/car_lane_driver.sv | 132 +++++++++++++
 tb/tb_car_lane_driver.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/car_lane_driver_pkg.sv
// Playfield constants shared by every lane driver and by the display/collision logic.
package car_lane_driver_pkg;
  localparam int TILE_SIZE          = 16;
  localparam int H_VISIBLE_AREA     = 640;
  localparam int STEP_LIMIT_DEFAULT = 250000;
  localparam int POS_W              = 10;
  localparam int ARITH_W            = 11;
endpackage

// File: rtl/car_lane_driver.sv
// One traffic lane: a single car moving horizontally at a fixed row and wrapping at the screen edge.
module car_lane_driver
  import car_lane_driver_pkg::*;
#(
  parameter int TILE_SIZE      = car_lane_driver_pkg::TILE_SIZE,
  parameter int H_VISIBLE_AREA = car_lane_driver_pkg::H_VISIBLE_AREA,
  parameter int c_LANE_ROW     = 10,
  parameter int c_START_X      = 128,
  parameter int c_STEP_LIMIT   = car_lane_driver_pkg::STEP_LIMIT_DEFAULT,
  parameter int c_DIRECTION    = 0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic       i_Freeze,
  input  logic [1:0] i_Level,
  output logic [9:0] o_Car_X,
  output logic [9:0] o_Car_Y,
  output logic       o_Step,
  output logic       o_Wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int                   DIV_W    = $clog2(c_STEP_LIMIT);
  localparam logic [DIV_W-1:0]     DIV_TERM = DIV_W'(c_STEP_LIMIT - 1);
  localparam logic [ARITH_W-1:0]   H_AREA   = ARITH_W'(H_VISIBLE_AREA);
  localparam logic [POS_W-1:0]     START_X  = POS_W'(c_START_X);
  localparam logic [POS_W-1:0]     CAR_Y    = POS_W'(c_LANE_ROW * TILE_SIZE);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [POS_W-1:0] x_q, x_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [POS_W-1:0] next_x;
  logic             next_wrap;

  // Returns {wrapped, new_x}; 11-bit arithmetic keeps X+S and X+H-S from overflowing.
  function automatic logic [POS_W:0] step_pos(input logic [POS_W-1:0] x,
                                              input logic [1:0]       lvl);
    logic [ARITH_W-1:0] x_w;
    logic [ARITH_W-1:0] s_w;
    logic [ARITH_W-1:0] res;
    logic               w;
    x_w = {1'b0, x};
    s_w = {{(ARITH_W-2){1'b0}}, lvl} + {{(ARITH_W-1){1'b0}}, 1'b1};
    w   = 1'b0;
    if (c_DIRECTION == 0) begin
      res = x_w + s_w;
      if (res >= H_AREA) begin
        res = res - H_AREA;
        w   = 1'b1;
      end
    end else if (x_w >= s_w) begin
      res = x_w - s_w;
    end else begin
      res = x_w + H_AREA - s_w;
      w   = 1'b1;
    end
    return {w, POS_W'(res)};
  endfunction

  always_comb begin
    state_d             = state_q;
    div_d               = div_q;
    x_d                 = x_q;
    step_d              = 1'b0;
    wrap_d              = 1'b0;
    {next_wrap, next_x} = step_pos(x_q, i_Level);
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (i_Enable) state_d = i_Freeze ? HOLD : RUN;
      end
      RUN: begin
        if (!i_Enable) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (i_Freeze) begin
          // Freeze wins even on the terminal count: the step is dropped, the divider parks.
          state_d = HOLD;
        end else if (div_q == DIV_TERM) begin
          div_d  = '0;
          x_d    = next_x;
          step_d = 1'b1;
          wrap_d = next_wrap;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HOLD: begin
        if (!i_Enable) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (!i_Freeze) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      x_q     <= START_X;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_Car_X = x_q;
  assign o_Car_Y = CAR_Y;
  assign o_Step  = step_q;
  assign o_Wrap  = wrap_q;

endmodule

// File: tb/tb_car_lane_driver.sv
// Bench for car_lane_driver: one right-moving and one left-moving lane against a cycle model and step scoreboard.
module tb_car_lane_driver;
  localparam int LIM    = 4;
  localparam int START  = 128;
  localparam int HV     = 640;
  localparam int LANE_Y = 160;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst   [2];
  logic       en    [2];
  logic       frz   [2];
  logic [1:0] lvl   [2];
  logic [9:0] car_x [2];
  logic [9:0] car_y [2];
  logic       step  [2];
  logic       wrap  [2];

  int         mst   [2];
  int         mdiv  [2];
  int         mx    [2];
  logic       mstep [2];
  logic       mwrap [2];
  logic [10:0] sb0[$];
  logic [10:0] sb1[$];

  int checks = 0;
  int errors = 0;

  car_lane_driver #(.c_STEP_LIMIT(LIM), .c_START_X(START), .c_DIRECTION(0)) dut_r (
    .i_Clk(clk), .i_Reset(rst[0]), .i_Enable(en[0]), .i_Freeze(frz[0]), .i_Level(lvl[0]),
    .o_Car_X(car_x[0]), .o_Car_Y(car_y[0]), .o_Step(step[0]), .o_Wrap(wrap[0])
  );

  car_lane_driver #(.c_STEP_LIMIT(LIM), .c_START_X(START), .c_DIRECTION(1)) dut_l (
    .i_Clk(clk), .i_Reset(rst[1]), .i_Enable(en[1]), .i_Freeze(frz[1]), .i_Level(lvl[1]),
    .o_Car_X(car_x[1]), .o_Car_Y(car_y[1]), .o_Step(step[1]), .o_Wrap(wrap[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    mst[d]   = M_IDLE;
    mdiv[d]  = 0;
    mx[d]    = START;
    mstep[d] = 1'b0;
    mwrap[d] = 1'b0;
  endtask

  task automatic model_move(input int d);
    int s;
    int nx;
    s  = int'(lvl[d]) + 1;
    mwrap[d] = 1'b0;
    if (d == 0) begin
      nx = mx[d] + s;
      if (nx >= HV) begin nx = nx - HV; mwrap[d] = 1'b1; end
    end else if (mx[d] >= s) begin
      nx = mx[d] - s;
    end else begin
      nx = mx[d] + HV - s;
      mwrap[d] = 1'b1;
    end
    mx[d]    = nx;
    mstep[d] = 1'b1;
    if (d == 0) sb0.push_back({mwrap[d], 10'(nx)});
    else        sb1.push_back({mwrap[d], 10'(nx)});
  endtask

  task automatic model_clock(input int d);
    mstep[d] = 1'b0;
    mwrap[d] = 1'b0;
    if (rst[d]) model_reset(d);
    else case (mst[d])
      M_IDLE: begin
        mdiv[d] = 0;
        if (en[d]) mst[d] = frz[d] ? M_HOLD : M_RUN;
      end
      M_RUN: begin
        if (!en[d]) begin mst[d] = M_IDLE; mdiv[d] = 0; end
        else if (frz[d]) mst[d] = M_HOLD;
        else if (mdiv[d] == LIM - 1) begin mdiv[d] = 0; model_move(d); end
        else mdiv[d] = mdiv[d] + 1;
      end
      default: begin
        if (!en[d]) begin mst[d] = M_IDLE; mdiv[d] = 0; end
        else if (!frz[d]) mst[d] = M_RUN;
      end
    endcase
  endtask

  task automatic monitor(input int d);
    logic [10:0] e;
    chk($sformatf("step%0d", d), 32'(step[d]), 32'(mstep[d]));
    chk($sformatf("wrap%0d", d), 32'(wrap[d]), 32'(mwrap[d]));
    chk($sformatf("y%0d", d), 32'(car_y[d]), LANE_Y);
    if (step[d]) begin
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        chk($sformatf("sb_underflow%0d", d), 32'(step[d]), 32'd0);
      end else begin
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        chk($sformatf("sb_x%0d", d), 32'(car_x[d]), 32'(e[9:0]));
        chk($sformatf("sb_wrap%0d", d), 32'(wrap[d]), 32'(e[10]));
      end
    end else begin
      chk($sformatf("x_hold%0d", d), 32'(car_x[d]), 32'(mx[d]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_clock(d);
    #1;
    for (int d = 0; d < 2; d++) monitor(d);
  endtask

  task automatic run_until(input int d, input int target, input int budget);
    int n;
    n = 0;
    while (mx[d] != target && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("reach%0d_%0d", d, target), 32'(car_x[d]), 32'(target));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; frz[d] = 1'b0; lvl[d] = 2'd0;
      model_reset(d);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_x", 32'(car_x[d]), START);
      chk("rst_y", 32'(car_y[d]), LANE_Y);
      chk("rst_step", 32'(step[d]), 0);
      chk("rst_wrap", 32'(wrap[d]), 0);
    end
    tick(); tick();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Right lane: first steps, four RUN cycles apart.
    en[0] = 1'b1;
    tick();
    repeat (4) tick();
    chk("first_x129", 32'(car_x[0]), 129);
    chk("first_step", 32'(step[0]), 1);
    repeat (4) tick();
    chk("x130", 32'(car_x[0]), 130);
    repeat (4) tick();
    chk("x131", 32'(car_x[0]), 131);

    // Freeze two cycles into a period for ten cycles.
    repeat (2) tick();
    frz[0] = 1'b1;
    repeat (10) tick();
    chk("frozen_x", 32'(car_x[0]), 131);
    frz[0] = 1'b0;
    repeat (2) tick();
    chk("resume_nostep", 32'(step[0]), 0);
    tick();
    chk("resume_x132", 32'(car_x[0]), 132);
    chk("resume_step", 32'(step[0]), 1);

    // Freeze landing on the terminal count.
    repeat (3) tick();
    frz[0] = 1'b1;
    tick();
    chk("term_frz_nostep", 32'(step[0]), 0);
    chk("term_frz_x", 32'(car_x[0]), 132);
    frz[0] = 1'b0;
    repeat (2) tick();
    chk("term_resume_x133", 32'(car_x[0]), 133);

    // Freeze and disable together: back to IDLE with the divider cleared.
    tick();
    frz[0] = 1'b1; en[0] = 1'b0;
    tick();
    chk("idle_x", 32'(car_x[0]), 133);
    frz[0] = 1'b0; en[0] = 1'b1;
    repeat (4) tick();
    chk("idle_restart_nostep", 32'(step[0]), 0);
    tick();
    chk("idle_restart_x134", 32'(car_x[0]), 134);

    // Level changes mid-period; only the value at the step cycle matters.
    lvl[0] = 2'd3;
    repeat (2) tick();
    lvl[0] = 2'd1;
    repeat (2) tick();
    chk("lvl_sample_x136", 32'(car_x[0]), 136);

    lvl[0] = 2'd3;
    run_until(0, 636, 2000);
    lvl[0] = 2'd1;
    run_until(0, 638, 100);
    lvl[0] = 2'd2;
    repeat (4) tick();
    chk("rwrap_x1", 32'(car_x[0]), 1);
    chk("rwrap_step", 32'(step[0]), 1);
    chk("rwrap_wrap", 32'(wrap[0]), 1);
    en[0] = 1'b0;
    tick();

    // Left lane.
    en[1] = 1'b1; lvl[1] = 2'd3;
    tick();
    run_until(1, 4, 2000);
    lvl[1] = 2'd1;
    run_until(1, 2, 100);
    repeat (4) tick();
    chk("left_x0", 32'(car_x[1]), 0);
    chk("left_x0_step", 32'(step[1]), 1);
    chk("left_x0_nowrap", 32'(wrap[1]), 0);
    lvl[1] = 2'd0;
    repeat (4) tick();
    chk("left_from0_x639", 32'(car_x[1]), 639);
    chk("left_from0_wrap", 32'(wrap[1]), 1);
    lvl[1] = 2'd3;
    run_until(1, 3, 2000);
    lvl[1] = 2'd1;
    run_until(1, 1, 100);
    repeat (4) tick();
    chk("left_from1_x639", 32'(car_x[1]), 639);
    chk("left_from1_wrap", 32'(wrap[1]), 1);
    en[1] = 1'b0;
    tick();

    // Right lane to X=200, then reset mid-period.
    en[0] = 1'b1; lvl[0] = 2'd2;
    tick();
    run_until(0, 4, 100);
    lvl[0] = 2'd3;
    run_until(0, 200, 2000);
    repeat (2) tick();
    rst[0] = 1'b1;
    #1;
    chk("midrst_x", 32'(car_x[0]), START);
    chk("midrst_step", 32'(step[0]), 0);
    chk("midrst_wrap", 32'(wrap[0]), 0);
    model_reset(0);
    tick();
    rst[0] = 1'b0;
    tick();
    repeat (3) tick();
    chk("postrst_nostep", 32'(step[0]), 0);
    tick();
    chk("postrst_x132", 32'(car_x[0]), 132);
    chk("postrst_step", 32'(step[0]), 1);

    chk("sb0_drain", 32'(sb0.size()), 0);
    chk("sb1_drain", 32'(sb1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
